// File: rtl/mac_accumulator.sv
// Frame accumulator for unsigned 8-bit products: sums terms until in_last or
// MAX_TERMS, saturating at 2^ACC_W-1, then holds the result until handed off.
module mac_accumulator #(
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [7:0]       out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0]       MAX_CNT = 8'(MAX_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_count;
    logic             r_ovf;

    logic             w_accept;
    logic             w_first;
    logic [ACC_W:0]   w_sum;
    logic             w_sat;
    logic [7:0]       w_cnt_next;
    logic             w_ends;

    // Handshakes: a term transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready. Neither
    // side may withdraw or change its payload while waiting for the other.
    assign w_accept   = in_valid && in_ready;
    assign w_first    = (r_state == S_IDLE);
    assign w_sum      = (w_first ? {(ACC_W+1){1'b0}} : {1'b0, r_acc})
                      + {{(ACC_W-7){1'b0}}, prod};
    assign w_sat      = w_sum[ACC_W];
    assign w_cnt_next = w_first ? 8'd1 : r_count + 8'd1;
    assign w_ends     = in_last || (w_cnt_next == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    w_next = w_ends ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE, S_ACCUM: in_ready  = 1'b1;
            S_HOLD:          out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // A fresh frame discards the previous overflow flag; within a frame it is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sat ? ACC_MAX : w_sum[ACC_W-1:0];
            r_count <= w_cnt_next;
            r_ovf   <= (w_first ? 1'b0 : r_ovf) | w_sat;
        end
    end

    assign out_data  = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 12-bit and an 8-bit instance share one
// input stream so saturation can be observed alongside the wide result.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  prod;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic [11:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf;
    logic        out_valid;
    logic [1:0]  dbg_state;

    logic        in_ready8;
    logic [7:0]  out_data8;
    logic [7:0]  out_count8;
    logic        out_ovf8;
    logic        out_valid8;
    logic [1:0]  dbg_state8;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;

    always #5 clk = ~clk;

    mac_accumulator #(.ACC_W(12), .MAX_TERMS(16)) u_dut (
        .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
        .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .dbg_state(dbg_state)
    );

    mac_accumulator #(.ACC_W(8), .MAX_TERMS(16)) u_dut8 (
        .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready8), .out_data(out_data8), .out_count(out_count8),
        .out_ovf(out_ovf8), .out_valid(out_valid8), .out_ready(out_ready),
        .dbg_state(dbg_state8)
    );

    // Drives one term for a single cycle; caller guarantees the DUT is not in HOLD.
    task automatic send_term(input logic [7:0] p, input logic last);
        prod     = p;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; prod = 8'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 12'd0) begin n_err++; $display("FAIL rst_data: got %0d want 0", out_data); end
        n_vec++; if (out_count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", out_count); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %0b want 0", out_ovf); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_three_term();
        out_ready = 1'b1;
        send_term(8'd6, 1'b0);
        send_term(8'd15, 1'b0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL three_early_valid: got %0b want 0", out_valid); end
        send_term(8'd9, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL three_valid: got %0b want 1", out_valid); end
        n_vec++; if (out_data !== 12'd30) begin n_err++; $display("FAIL three_data: got %0d want 30", out_data); end
        n_vec++; if (out_count !== 8'd3) begin n_err++; $display("FAIL three_count: got %0d want 3", out_count); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL three_ovf: got %0b want 0", out_ovf); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL three_hold_ready: got %0b want 0", in_ready); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL three_handoff: got %0b want 0", out_valid); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL three_idle: got %0d want 0", dbg_state); end
    endtask

    task automatic test_full_length();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_term(8'd225, 1'b0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_count !== 8'd15) begin n_err++; $display("FAIL full_count15: got %0d want 15", out_count); end
        send_term(8'd225, 1'b0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %0b want 1", out_valid); end
        n_vec++; if (out_data !== 12'd3600) begin n_err++; $display("FAIL full_data: got %0d want 3600", out_data); end
        n_vec++; if (out_count !== 8'd16) begin n_err++; $display("FAIL full_count: got %0d want 16", out_count); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf: got %0b want 0", out_ovf); end
        n_vec++; if (out_data8 !== 8'd255) begin n_err++; $display("FAIL full_data8: got %0d want 255", out_data8); end
        n_vec++; if (out_ovf8 !== 1'b1) begin n_err++; $display("FAIL full_ovf8: got %0b want 1", out_ovf8); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        send_term(8'd200, 1'b0);
        send_term(8'd100, 1'b1);
        n_vec++; if (out_valid8 !== 1'b1) begin n_err++; $display("FAIL ovf_valid8: got %0b want 1", out_valid8); end
        n_vec++; if (out_data8 !== 8'd255) begin n_err++; $display("FAIL ovf_data8: got %0d want 255", out_data8); end
        n_vec++; if (out_ovf8 !== 1'b1) begin n_err++; $display("FAIL ovf_flag8: got %0b want 1", out_ovf8); end
        n_vec++; if (out_data !== 12'd300) begin n_err++; $display("FAIL ovf_wide_data: got %0d want 300", out_data); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_wide_flag: got %0b want 0", out_ovf); end
        @(negedge clk);
        send_term(8'd5, 1'b1);
        n_vec++; if (out_data8 !== 8'd5) begin n_err++; $display("FAIL ovf_next_data8: got %0d want 5", out_data8); end
        n_vec++; if (out_ovf8 !== 1'b0) begin n_err++; $display("FAIL ovf_next_flag8: got %0b want 0", out_ovf8); end
        n_vec++; if (out_count8 !== 8'd1) begin n_err++; $display("FAIL ovf_next_count8: got %0d want 1", out_count8); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_term(8'd10, 1'b0);
        send_term(8'd20, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %0b want 1", out_valid); end
        prod = 8'd99; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", i, out_valid); end
            n_vec++; if (out_data !== 12'd30) begin n_err++; $display("FAIL bp_data[%0d]: got %0d want 30", i, out_data); end
            n_vec++; if (out_count !== 8'd2) begin n_err++; $display("FAIL bp_count[%0d]: got %0d want 2", i, out_count); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        // in_valid stayed high through the handoff edge; the term must wait for IDLE.
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %0b want 1", out_valid); end
        n_vec++; if (out_data !== 12'd99) begin n_err++; $display("FAIL bp_next_data: got %0d want 99", out_data); end
        n_vec++; if (out_count !== 8'd1) begin n_err++; $display("FAIL bp_next_count: got %0d want 1", out_count); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_next_handoff: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        send_term(8'd40, 1'b0);
        send_term(8'd41, 1'b0);
        // Reset coincides with an offered last term, which must be dropped.
        rst = 1'b1; prod = 8'd33; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        n_vec++; if (out_count !== 8'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", out_count); end
        n_vec++; if (out_data !== 12'd0) begin n_err++; $display("FAIL rmid_data: got %0d want 0", out_data); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid[%0d]: got %0b want 0", i, out_valid); end
            @(negedge clk);
        end
        send_term(8'd7, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_next_valid: got %0b want 1", out_valid); end
        n_vec++; if (out_data !== 12'd7) begin n_err++; $display("FAIL rmid_next_data: got %0d want 7", out_data); end
        n_vec++; if (out_count !== 8'd1) begin n_err++; $display("FAIL rmid_next_count: got %0d want 1", out_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_hold();
        out_ready = 1'b0;
        send_term(8'd50, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rhold_valid: got %0b want 1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rhold_state: got %0d want 0", dbg_state); end
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rhold_after[%0d]: got %0b want 0", i, out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_gapped_and_zero();
        out_ready = 1'b1;
        send_term(8'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid[%0d]: got %0b want 0", i, out_valid); end
            n_vec++; if (out_count !== 8'd1) begin n_err++; $display("FAIL gap_idle_count[%0d]: got %0d want 1", i, out_count); end
            @(negedge clk);
        end
        send_term(8'd4, 1'b1);
        n_vec++; if (out_data !== 12'd7) begin n_err++; $display("FAIL gap_data: got %0d want 7", out_data); end
        n_vec++; if (out_count !== 8'd2) begin n_err++; $display("FAIL gap_count: got %0d want 2", out_count); end
        @(negedge clk);
        send_term(8'd0, 1'b0);
        send_term(8'd0, 1'b0);
        send_term(8'd5, 1'b1);
        n_vec++; if (out_data !== 12'd5) begin n_err++; $display("FAIL zero_data: got %0d want 5", out_data); end
        n_vec++; if (out_count !== 8'd3) begin n_err++; $display("FAIL zero_count: got %0d want 3", out_count); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_three_term();
        test_full_length();
        test_overflow();
        test_backpressure();
        test_reset_mid_frame();
        test_reset_in_hold();
        test_gapped_and_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator and result width in bits (minimum 8).
REQ-002 SHALL have parameter MAX_TERMS, default 16: maximum products per frame (range 1..255).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port prod, input, 8: unsigned 4x4 product taken directly from the upstream array multiplier output.
REQ-006 SHALL have port in_valid, input, 1: prod and in_last are valid this cycle.
REQ-007 SHALL have port in_last, input, 1: the accompanying product is the final term of the frame.
REQ-008 SHALL have port in_ready, output, 1: the block accepts a term this cycle.
REQ-009 SHALL have port out_data, output, ACC_W: accumulated frame sum.
REQ-010 SHALL have port out_count, output, 8: number of terms in the frame.
REQ-011 SHALL have port out_ovf, output, 1: the frame sum saturated.
REQ-012 SHALL have port out_valid, output, 1: out_data, out_count and out_ovf are valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the result.

Function
REQ-014 SHALL accept a term only on a cycle where in_valid=1 and in_ready=1.
REQ-015 SHALL implement an FSM with states IDLE, ACCUM and HOLD.
REQ-016 SHALL assert in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-017 IDLE: on an accepted term, SHALL load acc=prod and count=1, then go to ACCUM, or to HOLD if the term ends the frame (REQ-019).
REQ-018 ACCUM: on an accepted term, SHALL set acc=acc+prod and count=count+1, and remain in ACCUM unless the term ends the frame.
REQ-019 A term SHALL end the frame when in_last=1 or when the post-accept count equals MAX_TERMS; the transition is then to HOLD.
REQ-020 SHALL assert out_valid=1 exactly in HOLD, so results appear one cycle after the final accept.
REQ-021 out_data, out_count and out_ovf SHALL be registered and held stable while out_valid=1.
REQ-022 HOLD: when out_ready=1, SHALL go to IDLE on the next edge and deassert out_valid.
REQ-023 HOLD: when out_ready=0, SHALL remain in HOLD indefinitely without losing data.
REQ-024 SHALL NOT accept a new term in the same cycle as a result handoff; the next frame starts in IDLE at the earliest.
REQ-025 Additions SHALL be unsigned and zero-extend prod to ACC_W+1 bits.
REQ-026 When a sum exceeds 2^ACC_W-1, SHALL clamp acc to 2^ACC_W-1 and set ovf; ovf stays set until the frame's result handoff.
REQ-027 SHALL clear ovf on every IDLE frame start.
REQ-028 ACCUM with in_valid=0 SHALL leave acc and count unchanged, with no timeout.
REQ-029 in_last=1 on the first term SHALL produce a one-term frame with out_count=1.
REQ-030 prod=0 terms SHALL be counted normally.

Reset
REQ-031 With rst=1 at a clock edge, SHALL set the state to IDLE and clear acc, count and ovf.
REQ-032 During reset, outputs SHALL be out_valid=0, out_data=0, out_count=0 and out_ovf=0, and in_ready SHALL be 1 from the first cycle after reset release.
REQ-033 Reset mid-frame or in HOLD SHALL discard the partial or pending result, and no out_valid pulse SHALL follow.
REQ-034 rst SHALL take priority over any simultaneous accept or handoff.

Verification
REQ-035 Three-term frame: prods 6,15,9 with in_last on the third, out_ready=1 -> out_valid one cycle after the third accept with out_data=30, out_count=3, out_ovf=0, then IDLE.
REQ-036 Full-length frame: 16 prods of 225, in_last=0 throughout -> frame closes at count 16 with out_data=3600, out_count=16, out_ovf=0.
REQ-037 Overflow: with ACC_W=8, prods 200 then 100 with in_last -> out_data=255, out_ovf=1; the next frame, a single prod 5, gives out_ovf=0.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles after a result with in_valid=1 -> in_ready=0, out_data stable; releasing out_ready gives one handoff, then in_ready=1.
REQ-039 Reset mid-frame: two terms accepted, then rst=1 -> out_valid never asserts, and a following single term 7 with in_last yields out_data=7, out_count=1.
REQ-040 Gapped input: prods 3, (2 idle cycles), 4 with in_last -> out_data=7, out_count=2.
